// File: rtl/gmii_tx_framer.sv
// gmii_tx_framer
//   Transmit-side Ethernet framer. Takes a payload byte stream (destination
//   MAC through last payload byte) with a valid/ready/last handshake and
//   produces a complete GMII frame on txd/txen/txer. The frame is built as
//   7x 0x55 preamble, 0xD5 SFD, the payload, zero pad up to MIN_LEN, the
//   CRC32 FCS (LSB byte first), and then an inter-frame gap.
//
// Ports
//   clk           GMII transmit clock; all logic on the rising edge
//   I_rst         synchronous reset, active high
//   I_tx_data     payload byte
//   I_tx_valid    I_tx_data is valid
//   I_tx_last     current byte is the last of the frame (qualified by valid)
//   O_tx_ready    byte is accepted on valid & ready
//   O_gmii_txd    GMII data, registered
//   O_gmii_txen   GMII transmit enable, registered
//   O_gmii_txer   GMII transmit error, registered
//   O_frame_done  one-cycle pulse, coincident with the last FCS byte on txd
//   O_underflow   one-cycle pulse, coincident with the aborting txer cycle
//
// States
//   ST_IDLE | txen low; a valid byte (held, not consumed) starts a frame
//   ST_PRE  | emitting the 0x55 preamble
//   ST_SFD  | emitting 0xD5
//   ST_DATA | accepting payload bytes; each appears on txd the next cycle
//   ST_PAD  | emitting 0x00 until payload+pad reaches MIN_LEN
//   ST_FCS  | emitting the four inverted-CRC bytes, LSB first
//   ST_IFG  | txen low for IFG_CYCLES, input ignored

module gmii_tx_framer #(
    parameter int MIN_LEN    = 60,
    parameter int MAX_LEN    = 1514,
    parameter int IFG_CYCLES = 12
) (
    input  logic       clk,
    input  logic       I_rst,
    input  logic [7:0] I_tx_data,
    input  logic       I_tx_valid,
    input  logic       I_tx_last,
    output logic       O_tx_ready,
    output logic [7:0] O_gmii_txd,
    output logic       O_gmii_txen,
    output logic       O_gmii_txer,
    output logic       O_frame_done,
    output logic       O_underflow
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DATA,
        ST_PAD,
        ST_FCS,
        ST_IFG
    } state_t;

    localparam logic [10:0] MIN_L    = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L    = 11'(MAX_LEN);
    localparam logic [7:0]  IFG_LOAD = 8'(IFG_CYCLES - 1);

    state_t      state;
    logic [10:0] byte_cnt;
    logic [31:0] crc;
    logic [7:0]  phase_cnt;
    logic [31:0] fcs;

    // Reflected CRC32 (0xEDB88320), one byte per call, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        end
        return r;
    endfunction

    // Ready also drops once MAX_LEN bytes are in, so the extra byte stays
    // with the source and starts the next frame after the abort.
    assign O_tx_ready = (state == ST_DATA) && (byte_cnt != MAX_L);
    assign fcs        = ~crc;

    always_ff @(posedge clk) begin
        if (I_rst) begin
            state        <= ST_IDLE;
            byte_cnt     <= 11'd0;
            crc          <= 32'hFFFF_FFFF;
            phase_cnt    <= 8'd0;
            O_gmii_txd   <= 8'd0;
            O_gmii_txen  <= 1'b0;
            O_gmii_txer  <= 1'b0;
            O_frame_done <= 1'b0;
            O_underflow  <= 1'b0;
        end else begin
            O_gmii_txer  <= 1'b0;
            O_frame_done <= 1'b0;
            O_underflow  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    O_gmii_txen <= 1'b0;
                    O_gmii_txd  <= 8'd0;
                    crc         <= 32'hFFFF_FFFF;
                    byte_cnt    <= 11'd0;
                    if (I_tx_valid) begin
                        state       <= ST_PRE;
                        O_gmii_txen <= 1'b1;
                        O_gmii_txd  <= 8'h55;
                        phase_cnt   <= 8'd1;
                    end
                end
                ST_PRE: begin
                    O_gmii_txd <= 8'h55;
                    if (phase_cnt == 8'd6) begin
                        state <= ST_SFD;
                    end else begin
                        phase_cnt <= phase_cnt + 8'd1;
                    end
                end
                ST_SFD: begin
                    O_gmii_txd <= 8'hD5;
                    state      <= ST_DATA;
                end
                ST_DATA: begin
                    if (O_tx_ready && I_tx_valid) begin
                        O_gmii_txd <= I_tx_data;
                        crc        <= crc_byte(crc, I_tx_data);
                        byte_cnt   <= byte_cnt + 11'd1;
                        if (I_tx_last) begin
                            if ((byte_cnt + 11'd1) < MIN_L) begin
                                state <= ST_PAD;
                            end else begin
                                state     <= ST_FCS;
                                phase_cnt <= 8'd0;
                            end
                        end
                    end else begin
                        // Source starved us or the frame is oversize: poison it.
                        O_gmii_txd  <= 8'd0;
                        O_gmii_txer <= 1'b1;
                        O_underflow <= 1'b1;
                        state       <= ST_IFG;
                        phase_cnt   <= IFG_LOAD;
                    end
                end
                ST_PAD: begin
                    O_gmii_txd <= 8'd0;
                    crc        <= crc_byte(crc, 8'd0);
                    byte_cnt   <= byte_cnt + 11'd1;
                    if ((byte_cnt + 11'd1) == MIN_L) begin
                        state     <= ST_FCS;
                        phase_cnt <= 8'd0;
                    end
                end
                ST_FCS: begin
                    case (phase_cnt[1:0])
                        2'd0:    O_gmii_txd <= fcs[7:0];
                        2'd1:    O_gmii_txd <= fcs[15:8];
                        2'd2:    O_gmii_txd <= fcs[23:16];
                        default: O_gmii_txd <= fcs[31:24];
                    endcase
                    if (phase_cnt[1:0] == 2'd3) begin
                        O_frame_done <= 1'b1;
                        state        <= ST_IFG;
                        phase_cnt    <= IFG_LOAD;
                    end else begin
                        phase_cnt <= phase_cnt + 8'd1;
                    end
                end
                ST_IFG: begin
                    O_gmii_txen <= 1'b0;
                    O_gmii_txd  <= 8'd0;
                    if (phase_cnt == 8'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end
                default: begin
                    state       <= ST_IDLE;
                    O_gmii_txen <= 1'b0;
                    O_gmii_txd  <= 8'd0;
                end
            endcase
        end
    end

endmodule
